// File: rtl/fifo_queue_pkg.sv
// -----------------------------------------------------------------------------
// fifo_queue_pkg
//   Shared definitions for the fifo_queue block and its benches.
//   - FIFO_WIDTH / FIFO_DEPTH : default data width and entry count, kept here
//     so the FIFO and the LIFO lab benches build with identical sizes.
//   - fifo_op_t               : the effective operations granted on one edge.
//   - resolve_op()            : maps raw push/pop requests plus the current
//     occupancy onto the operations that actually take place.
// -----------------------------------------------------------------------------
package fifo_queue_pkg;

    localparam int FIFO_WIDTH = 8;
    localparam int FIFO_DEPTH = 4;

    typedef struct packed {
        logic do_push;
        logic do_pop;
    } fifo_op_t;

    // A pop is only honoured when there is something to pop.
    // A push is honoured when there is room, or when a pop frees a slot on
    // the same edge.
    function automatic fifo_op_t resolve_op(input logic push,
                                            input logic pop,
                                            input logic empty,
                                            input logic full);
        fifo_op_t op;
        op.do_pop  = pop & ~empty;
        op.do_push = push & (~full | op.do_pop);
        return op;
    endfunction

endpackage : fifo_queue_pkg

// File: rtl/fifo_ram.sv
// -----------------------------------------------------------------------------
// fifo_ram
//   Simple dual-port register array used as FIFO storage.
//   Ports:
//     clk   in            write clock (rising edge)
//     we    in            write enable
//     waddr in  ADDR_W    write address
//     wdata in  WIDTH     write data
//     raddr in  ADDR_W    read address
//     rdata out WIDTH     asynchronous read data (mem[raddr])
// -----------------------------------------------------------------------------
module fifo_ram #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the array has no reset; stale words are never observable because
    // the read side masks everything outside the valid count, and leaving it
    // unreset lets it map onto plain storage without a reset tree.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule : fifo_ram

// File: rtl/fifo_queue.sv
// -----------------------------------------------------------------------------
// fifo_queue
//   Synchronous first-in/first-out queue with show-ahead read data, occupancy
//   status and sticky overflow/underflow flags. Drop-in ordering counterpart of
//   the stack_2 LIFO (same push/pop/write_data/read_data interface).
//   Ports:
//     clk        in            clock, all state changes on the rising edge
//     rst        in            asynchronous active-high reset
//     clear      in            synchronous flush (also clears error flags),
//                              wins over push/pop on the same edge
//     push       in            enqueue write_data on this edge
//     pop        in            dequeue the head entry on this edge
//     write_data in  WIDTH     data to enqueue
//     read_data  out WIDTH     head entry, 0 while empty
//     empty      out           no entries held
//     full       out           DEPTH entries held
//     count      out ADDR_W+1  number of valid entries, 0..DEPTH
//     overflow   out           sticky: a push was dropped
//     underflow  out           sticky: a pop found the queue empty
//   DEPTH must be a power of two >= 2 so the pointers wrap for free.
// -----------------------------------------------------------------------------
module fifo_queue
    import fifo_queue_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH,
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           write_data,
    output logic [WIDTH-1:0]           read_data,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q,  count_d;
    logic              overflow_q,  overflow_d;
    logic              underflow_q, underflow_d;

    fifo_op_t          op;
    logic              ram_we;
    logic [WIDTH-1:0]  ram_rdata;

    // Status comes straight from the count register, never from the pointers.
    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));

    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        op          = resolve_op(push, pop, empty, full);
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (clear) begin
            // Flush outranks any request on this edge.
            op          = '0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (op.do_push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;   // wraps modulo DEPTH
            end
            if (op.do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            // Push and pop together leave the occupancy unchanged.
            case ({op.do_push, op.do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            if (push && !op.do_push) begin
                overflow_d = 1'b1;
            end
            if (pop && empty) begin
                underflow_d = 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // The storage has no reset pin, so gate its write with rst to keep a push
    // on a reset edge from touching memory at all.
    assign ram_we = op.do_push & ~rst;

    fifo_ram #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_ptr_q),
        .wdata (write_data),
        .raddr (rd_ptr_q),
        .rdata (ram_rdata)
    );

    assign read_data = empty ? '0 : ram_rdata;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule : fifo_queue

// File: tb/tb_fifo_queue.sv
// -----------------------------------------------------------------------------
// tb_fifo_queue
//   Directed bench for fifo_queue. A queue of expected words is filled as
//   pushes are accepted and drained as pops are accepted; status and sticky
//   flags are predicted alongside it.
// -----------------------------------------------------------------------------
module tb_fifo_queue;
    import fifo_queue_pkg::*;

    localparam int WIDTH = FIFO_WIDTH;
    localparam int DEPTH = FIFO_DEPTH;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clk;
    logic             rst;
    logic             clear;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] write_data;
    logic [WIDTH-1:0] read_data;
    logic             empty;
    logic             full;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic             underflow;

    int errors = 0;
    int checks = 0;

    logic [WIDTH-1:0] sb[$];
    logic             exp_ovf;
    logic             exp_unf;

    fifo_queue #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .push       (push),
        .pop        (pop),
        .write_data (write_data),
        .read_data  (read_data),
        .empty      (empty),
        .full       (full),
        .count      (count),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        exp_ovf = 1'b0;
        exp_unf = 1'b0;
    endtask

    task automatic check_status(input string tag);
        logic [WIDTH-1:0] head;
        head = (sb.size() > 0) ? sb[0] : '0;
        check({tag, ".count"},     32'(count),     32'(sb.size()));
        check({tag, ".empty"},     32'(empty),     32'(sb.size() == 0));
        check({tag, ".full"},      32'(full),      32'(sb.size() == DEPTH));
        check({tag, ".read_data"}, 32'(read_data), 32'(head));
        check({tag, ".overflow"},  32'(overflow),  32'(exp_ovf));
        check({tag, ".underflow"}, 32'(underflow), 32'(exp_unf));
    endtask

    // One clock of stimulus: drive at the falling edge, predict, then check
    // 1 ns after the rising edge.
    task automatic step(input string tag, input logic p, input logic q,
                        input logic c, input logic [WIDTH-1:0] d);
        logic was_empty, g_pop, g_push;
        @(negedge clk);
        push = p; pop = q; clear = c; write_data = d;
        #1;
        if (c) begin
            model_reset();
        end else begin
            was_empty = (sb.size() == 0);
            g_pop     = q && !was_empty;
            g_push    = p && ((sb.size() < DEPTH) || g_pop);
            if (g_pop) begin
                // Scoreboard pop: the word leaving must be the one on the head.
                check({tag, ".pop_word"}, 32'(read_data), 32'(sb.pop_front()));
            end
            if (g_push) sb.push_back(d);
            if (q && was_empty) exp_unf = 1'b1;
            if (p && !g_push)   exp_ovf = 1'b1;
        end
        @(posedge clk);
        #1;
        check_status(tag);
    endtask

    task automatic idle();
        @(negedge clk);
        push = 1'b0; pop = 1'b0; clear = 1'b0; write_data = '0;
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; push = 1'b0; pop = 1'b0; write_data = '0;
        model_reset();
        #12;
        check_status("reset");
        @(negedge clk);
        rst = 1'b0;

        // Fill to full; head stays on the oldest word.
        for (int i = 1; i <= DEPTH; i++) step("fill", 1'b1, 1'b0, 1'b0, WIDTH'(i));
        check("fill.full_after_4", 32'(full), 32'd1);

        // Push into a full queue is dropped and flagged.
        step("ovf_push", 1'b1, 1'b0, 1'b0, 8'h05);
        check("ovf.head_kept", 32'(read_data), 32'h01);

        // Drain in FIFO order, ending empty with read_data 0.
        for (int i = 0; i < DEPTH; i++) step("drain", 1'b0, 1'b1, 1'b0, '0);
        check("drain.read_zero", 32'(read_data), 32'h0);

        // Pop on empty flags underflow only.
        step("unf_pop", 1'b0, 1'b1, 1'b0, '0);

        // Clear (with a push on the same edge) wipes flags and data.
        step("clear", 1'b1, 1'b0, 1'b1, 8'hEE);

        // Wrap-around with interleaved push/pop; pointers cross DEPTH-1 -> 0.
        step("wrap0", 1'b1, 1'b0, 1'b0, 8'hA0);
        for (int i = 1; i < 6; i++) begin
            step("wrap", 1'b1, 1'b1, 1'b0, 8'hA0 + 8'(i));
            check("wrap.count_le2", 32'(count <= 2), 32'd1);
        end
        step("wrap_last", 1'b0, 1'b1, 1'b0, '0);

        // Push+pop on full: both happen, count stays at DEPTH.
        for (int i = 1; i <= DEPTH; i++) step("refill", 1'b1, 1'b0, 1'b0, WIDTH'(i));
        step("full_pp", 1'b1, 1'b1, 1'b0, 8'h55);
        check("full_pp.head", 32'(read_data), 32'h02);
        for (int i = 0; i < DEPTH; i++) step("full_pp_drain", 1'b0, 1'b1, 1'b0, '0);

        // Push+pop on empty: push lands, pop flagged as underflow.
        step("empty_pp", 1'b1, 1'b1, 1'b0, 8'h66);
        check("empty_pp.head", 32'(read_data), 32'h66);

        // Asynchronous reset mid-cycle with three entries queued.
        step("pre_rst_clr", 1'b0, 1'b0, 1'b1, '0);
        for (int i = 0; i < 3; i++) step("pre_rst", 1'b1, 1'b0, 1'b0, 8'hC0 + 8'(i));
        idle();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_status("async_rst");
        // A push on an edge while rst is high is discarded.
        push = 1'b1; write_data = 8'hDD;
        @(posedge clk);
        #1;
        check_status("rst_edge_push");
        @(negedge clk);
        rst = 1'b0; push = 1'b0;
        step("post_rst", 1'b1, 1'b0, 1'b0, 8'h77);
        check("post_rst.head", 32'(read_data), 32'h77);
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_fifo_queue
